// File: rtl/avalon_master_arbiter.sv
// Two-requester Avalon-MM arbiter with round-robin tie-break and a watchdog
// that aborts transfers the downstream slave never finishes.
module avalon_master_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    iClk,
  input  logic                    iReset,
  input  logic                    r0Read,
  input  logic                    r0Write,
  input  logic [ADDR_WIDTH-1:0]   r0Addr,
  input  logic [DATA_WIDTH/8-1:0] r0BE,
  input  logic [DATA_WIDTH-1:0]   r0WriteData,
  output logic                    r0WaitReq,
  output logic                    r0ReadValid,
  output logic [DATA_WIDTH-1:0]   r0ReadData,
  input  logic                    r1Read,
  input  logic                    r1Write,
  input  logic [ADDR_WIDTH-1:0]   r1Addr,
  input  logic [DATA_WIDTH/8-1:0] r1BE,
  input  logic [DATA_WIDTH-1:0]   r1WriteData,
  output logic                    r1WaitReq,
  output logic                    r1ReadValid,
  output logic [DATA_WIDTH-1:0]   r1ReadData,
  output logic                    avalonRead,
  output logic                    avalonWrite,
  output logic                    avalonBeginTransfer,
  output logic [ADDR_WIDTH-1:0]   avalonAddr,
  output logic [DATA_WIDTH/8-1:0] avalonBE,
  output logic [DATA_WIDTH-1:0]   avalonWriteData,
  input  logic                    avalonWaitReq,
  input  logic                    avalonReadValid,
  input  logic [DATA_WIDTH-1:0]   avalonReadData,
  output logic [1:0]              oGrant,
  output logic                    oTimeout
);

  // A zero limit would give a zero-width counter, so keep one bit when disabled.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT_CYCLES);
  localparam logic WD_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, RDATA = 2'd2} state_t;

  state_t          state;
  logic            last_grant;
  logic            owner;
  logic [CW-1:0]   wdog;
  logic            req0;
  logic            req1;
  logic            win1;
  logic            progress;
  logic            abort;
  logic [DATA_WIDTH-1:0] ret_data;

  // Arbitration decision and watchdog abort qualification.
  always_comb begin
    req0 = r0Read | r0Write;
    req1 = r1Read | r1Write;
    win1 = req1 & (~req0 | ~last_grant);
    if (state == CMD) begin
      progress = ~avalonWaitReq;
    end else if (state == RDATA) begin
      progress = avalonReadValid;
    end else begin
      progress = 1'b0;
    end
    abort = WD_EN && (state != IDLE) && (wdog == TLIM) && !progress;
  end

  // Requester-side handshake; completion data takes precedence over the abort pattern.
  always_comb begin
    r0WaitReq   = 1'b1;
    r1WaitReq   = 1'b1;
    r0ReadValid = 1'b0;
    r1ReadValid = 1'b0;
    r0ReadData  = '0;
    r1ReadData  = '0;
    ret_data    = avalonReadValid ? avalonReadData : {DATA_WIDTH{1'b1}};
    if (state == CMD && (!avalonWaitReq || abort)) begin
      if (owner) begin
        r1WaitReq = 1'b0;
      end else begin
        r0WaitReq = 1'b0;
      end
    end else if (state == RDATA && (avalonReadValid || abort)) begin
      if (owner) begin
        r1ReadValid = 1'b1;
        r1ReadData  = ret_data;
      end else begin
        r0ReadValid = 1'b1;
        r0ReadData  = ret_data;
      end
    end else begin
      r0WaitReq = 1'b1;
    end
    oTimeout = abort;
  end

  // Transfer FSM with registered downstream command and grant.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state               <= IDLE;
      last_grant          <= 1'b1;
      owner               <= 1'b0;
      wdog                <= '0;
      oGrant              <= 2'b00;
      avalonRead          <= 1'b0;
      avalonWrite         <= 1'b0;
      avalonBeginTransfer <= 1'b0;
      avalonAddr          <= '0;
      avalonBE            <= '0;
      avalonWriteData     <= '0;
    end else begin
      avalonBeginTransfer <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state               <= CMD;
            owner               <= win1;
            last_grant          <= win1;
            oGrant              <= win1 ? 2'b10 : 2'b01;
            wdog                <= '0;
            avalonBeginTransfer <= 1'b1;
            avalonAddr          <= win1 ? r1Addr : r0Addr;
            avalonBE            <= win1 ? r1BE : r0BE;
            avalonWriteData     <= win1 ? r1WriteData : r0WriteData;
            // Write wins when a requester raises both strobes.
            avalonWrite         <= win1 ? r1Write : r0Write;
            avalonRead          <= win1 ? (r1Read & ~r1Write) : (r0Read & ~r0Write);
          end
        end
        CMD: begin
          if (wdog != TLIM) wdog <= wdog + CW'(1);
          if (!avalonWaitReq) begin
            avalonRead  <= 1'b0;
            avalonWrite <= 1'b0;
            if (avalonRead) begin
              state <= RDATA;
            end else begin
              state  <= IDLE;
              oGrant <= 2'b00;
            end
          end else if (abort) begin
            avalonRead  <= 1'b0;
            avalonWrite <= 1'b0;
            state       <= IDLE;
            oGrant      <= 2'b00;
          end
        end
        RDATA: begin
          if (wdog != TLIM) wdog <= wdog + CW'(1);
          if (avalonReadValid || abort) begin
            state  <= IDLE;
            oGrant <= 2'b00;
          end
        end
        default: begin
          state  <= IDLE;
          oGrant <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: doc/avalon_master_arbiter.md
AVALON_MASTER_ARBITER -- requirements
Module: avalon_master_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: address width of all Avalon ports.
REQ-002 Parameter DATA_WIDTH, default 32: data width of all Avalon ports; byte-enable width SHALL be DATA_WIDTH/8.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: watchdog limit in cycles; 0 SHALL disable the watchdog.
REQ-004 iClk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 iReset  in  1  asynchronous, active-high reset.
REQ-006 rNRead, rNWrite  in  1 each  requester N (N=0,1) read and write request.
REQ-007 rNAddr, rNBE, rNWriteData  in  ADDR_WIDTH, DATA_WIDTH/8, DATA_WIDTH  requester N command fields.
REQ-008 rNWaitReq  out  1  requester N wait request.
REQ-009 rNReadValid, rNReadData  out  1, DATA_WIDTH  requester N read return.
REQ-010 avalonRead, avalonWrite, avalonBeginTransfer  out  1 each  shared downstream command strobes.
REQ-011 avalonAddr, avalonBE, avalonWriteData  out  ADDR_WIDTH, DATA_WIDTH/8, DATA_WIDTH  shared downstream command fields.
REQ-012 avalonWaitReq, avalonReadValid, avalonReadData  in  1, 1, DATA_WIDTH  downstream response.
REQ-013 oGrant  out  2  one-hot owner of the downstream port, 00 when idle.
REQ-014 oTimeout  out  1  one-cycle pulse on watchdog abort.

Function
REQ-015 FSM states: IDLE, CMD (command on downstream, waiting for acceptance), RDATA (read accepted, waiting for avalonReadValid).
REQ-016 IDLE->CMD on the first edge where any rNRead or rNWrite is high.
REQ-017 Single requester: that requester SHALL be granted; both: the requester other than lastGrant SHALL be granted, and lastGrant SHALL update to the winner.
REQ-018 On IDLE->CMD, the winner's addr/BE/writeData/op SHALL be registered onto the avalon* outputs, so avalonRead/avalonWrite assert exactly 1 cycle after the request is first sampled.
REQ-019 avalonBeginTransfer SHALL be high only in the first CMD cycle of each transfer.
REQ-020 A requester asserting read and write together SHALL be served as a write; its read SHALL be ignored.
REQ-021 Downstream outputs SHALL hold stable for the whole CMD state regardless of requester input changes.
REQ-022 CMD, write, avalonWaitReq=0: transfer completes; next state IDLE; avalonWrite deasserts next cycle.
REQ-023 CMD, read, avalonWaitReq=0: next state RDATA; avalonRead deasserts next cycle.
REQ-024 RDATA, avalonReadValid=1: rNReadValid of the owner SHALL be high combinationally that cycle with rNReadData=avalonReadData; next state IDLE.
REQ-025 rNWaitReq SHALL be low only in the CMD cycle where N owns the port and avalonWaitReq=0 (combinational), or in the abort cycle (REQ-027); otherwise high, including while not requesting.
REQ-026 Non-owner rNReadValid SHALL be 0 and rNReadData SHALL be 0 whenever rNReadValid is 0.
REQ-027 Watchdog: counter cleared on entering CMD, incremented each cycle in CMD/RDATA; when it reaches TIMEOUT_CYCLES without completion: drop avalonRead/avalonWrite next cycle, pulse oTimeout, release owner (rNWaitReq low if in CMD; rNReadValid high with rNReadData all ones if in RDATA), return to IDLE.
REQ-028 Watchdog counter width SHALL be $clog2(TIMEOUT_CYCLES+1); the counter SHALL NOT wrap.
REQ-029 Completion and timeout in the same cycle: completion SHALL win; oTimeout SHALL stay 0.
REQ-030 A new grant SHALL NOT be issued before the FSM returns to IDLE; minimum 1 IDLE cycle between transfers.
REQ-031 oGrant SHALL be the registered owner in CMD/RDATA and 00 in IDLE.

Reset
REQ-032 iReset high SHALL immediately force state IDLE, lastGrant=1 (requester 0 wins the first tie), watchdog=0.
REQ-033 During reset: avalon* outputs 0, rNWaitReq 1, rNReadValid 0, rNReadData 0, oGrant 00, oTimeout 0.
REQ-034 Reset mid-transfer SHALL abandon the transfer without a completion or timeout pulse to any requester.

Verification
REQ-035 r0Write, addr 0xC7000000, data 0x12345678, BE 0xF, avalonWaitReq=0 -> avalonWrite+avalonBeginTransfer 1 cycle later with those values, r0WaitReq low that cycle, oGrant 01.
REQ-036 r0Read and r1Read same cycle after reset, downstream readData 0xA5A5A5A5 then 0x5A5A5A5A -> r0 served first, then r1; each rNReadValid only to its owner.
REQ-037 Both requesting continuously for 6 transfers -> grants alternate 0,1,0,1,0,1.
REQ-038 TIMEOUT_CYCLES=8, avalonWaitReq stuck high on r1Write -> oTimeout pulse 8 cycles after CMD entry, avalonWrite drops, r1WaitReq low one cycle, FSM IDLE.
REQ-039 Read accepted, avalonReadValid withheld past TIMEOUT_CYCLES -> r0ReadValid high with r0ReadData 0xFFFFFFFF, oTimeout pulse.
REQ-040 iReset asserted in RDATA -> all outputs at reset values without waiting for a clock edge; after release, r1 alone requesting is granted normally.
